fetch_queue: RTL and testbench

//   Parametrised instruction-fetch front end replacing the fixed PC register plus single IF/ID latch.

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared widths, polarity levels and constants for the instruction-fetch front end.
package fetch_queue_pkg;

    localparam int FQ_ADDR_W = 32;
    localparam int FQ_INST_W = 32;

    localparam logic RST_LVL = 1'b1;
    localparam logic CE_ON   = 1'b1;

    // Wide enough for any realistic instruction; narrowed at the point of use.
    localparam logic [63:0] ZERO_WORD = 64'h0;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of {pc, inst} words with clear, used by fetch_queue.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_LVL) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i && (rst != RST_LVL)) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation, ROM enable and a flushable fetch queue.
// Optional perf counters (perf_fetch_o, perf_stall_o) are enabled by defining FETCH_PERF_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              ADDR_W   = FQ_ADDR_W,
    parameter int              INST_W   = FQ_INST_W,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] rom_data_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_stall_o
`endif
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + INST_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               ce_q;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic               push, pop, valid;

    assign valid = (count != '0);
    assign pop   = valid & ~stall_i & ~flush_i;
    // A full queue still takes a new word when the head leaves in the same cycle.
    assign push  = (ce_q == CE_ON) & ~flush_i & ((count < CNT_W'(DEPTH)) | pop);

    always_comb begin
        pc_d = pc_q;
        if (flush_i)   pc_d = new_pc_i;
        else if (push) pc_d = pc_q + ADDR_W'(PC_STEP);
    end

    always_ff @(posedge clk) begin
        if (rst == RST_LVL) begin
            pc_q <= RESET_PC;
            ce_q <= ~CE_ON;
        end else begin
            pc_q <= pc_d;
            ce_q <= CE_ON;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush_i),
        .wdata_i ({pc_q, rom_data_i}),
        .count_o (count),
        .head_o  (head)
    );

    assign rom_addr_o = pc_q;
    assign rom_ce_o   = ce_q;
    assign id_valid_o = valid;
    assign id_pc_o    = valid ? head[ENTRY_W-1:INST_W] : ADDR_W'(ZERO_WORD);
    assign id_inst_o  = valid ? head[INST_W-1:0]       : INST_W'(ZERO_WORD);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (push)              perf_fetch_d = perf_fetch_q + 32'd1;
        if (valid && stall_i)  perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_LVL) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-level reference model predicts fetched words,
// a negedge monitor compares the ID outputs, address and enable against it.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic [31:0] rom_addr, rom_data, id_pc, id_inst;
    logic        rom_ce, id_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_stall;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        sb[$];
    int          mcount = 0;
    bit          mce = 1'b0;
    logic [31:0] mpc = '0;
    logic [31:0] m_fetch = '0;
    logic [31:0] m_stall = '0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_addr ^ KEY;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_data_i (rom_data),
        .rom_addr_o (rom_addr),
        .rom_ce_o   (rom_ce),
        .stall_i    (stall),
        .flush_i    (flush),
        .new_pc_i   (new_pc),
        .id_valid_o (id_valid),
        .id_pc_o    (id_pc),
        .id_inst_o  (id_inst)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_o (perf_fetch),
        .perf_stall_o (perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue-level model: applies the fetch rules to the inputs present at a rising edge.
    task automatic model_update();
        bit p, u;
        if (rst) begin
            mpc = '0; mce = 1'b0; mcount = 0; sb.delete();
            m_fetch = '0; m_stall = '0;
        end else begin
            if (mcount != 0 && stall) m_stall++;
            if (flush) begin
                mcount = 0; sb.delete(); mpc = new_pc;
            end else begin
                p = (mcount != 0) && !stall;
                u = mce && ((mcount < DEPTH) || p);
                if (u) begin
                    sb.push_back('{mpc, mpc ^ KEY});
                    mpc = mpc + 32'd4;
                    m_fetch++;
                end
                mcount = mcount + int'(u) - int'(p);
            end
            mce = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic f, input logic s, input logic [31:0] np);
        rst = r; flush = f; stall = s; new_pc = np;
        @(posedge clk);
        model_update();
        mon_en = 1'b1;
        #2;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rom_addr", {32'h0, rom_addr}, {32'h0, mpc});
            chk("rom_ce", {63'h0, rom_ce}, {63'h0, mce});
            chk("id_valid", {63'h0, id_valid}, {63'h0, mcount != 0});
            if (!id_valid) begin
                chk("nop_pc", {32'h0, id_pc}, 64'h0);
                chk("nop_inst", {32'h0, id_inst}, 64'h0);
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got id_valid=1 expected no queued entry at %0t", $time);
            end else begin
                chk("id_pc", {32'h0, id_pc}, {32'h0, sb[0].pc});
                chk("id_inst", {32'h0, id_inst}, {32'h0, sb[0].inst});
                if (!stall && !flush && !rst) void'(sb.pop_front());
            end
        end
    end

    initial begin
        // reset sequence then free-running fetch
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 32'h0);

        // fill to full under stall, then drain
        step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (6) step(1'b0, 1'b0, 1'b1, 32'h0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);

        // full with alternating stall
        repeat (4) step(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, logic'(i % 2), 32'h0);

        // flush with three entries queued
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h100);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);

        // flush while stalled, then flush colliding with reset
        repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h40);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h200);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);

        // PC wrap through the top of the address space
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

        // random traffic with occasional flush and mid-stream reset
        repeat (400)
            step(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC);

        // perf check after a clean fill-and-drain run
        step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (6) step(1'b0, 1'b0, 1'b1, 32'h0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
`ifdef FETCH_PERF_EN
        chk("perf_fetch", {32'h0, perf_fetch}, {32'h0, m_fetch});
        chk("perf_stall", {32'h0, perf_stall}, {32'h0, m_stall});
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
